// File: rtl/cfg_serial_loader_pkg.sv
// Shared definitions for the configuration serial loader: default register
// lengths, derived frame geometry and the controller state encoding.
package cfg_serial_loader_pkg;

   // Number of whole bytes needed to carry an n-bit frame
   function automatic int frame_bytes(input int n);
      return (n + 7) / 8;
   endfunction

   localparam int SIZESRSTAT_DEF  = 88;
   localparam int SIZESRDYN_DEF   = 16;
   localparam int FRAME_BITS_DEF  = SIZESRSTAT_DEF + SIZESRDYN_DEF;
   localparam int FRAME_BYTES_DEF = frame_bytes(FRAME_BITS_DEF);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LATCH = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/cfg_sclk_gen.sv
// Serial clock divider: while enabled it produces a low phase of CLKDIV
// cycles followed by a high phase of CLKDIV cycles, with single-cycle strobes
// marking the start of each period, the first high cycle and the last cycle.
module cfg_sclk_gen #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic srst,
   input  logic en,
   output logic sclk,
   output logic fall_stb,
   output logic rise_stb,
   output logic end_stb
);

   localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

   logic [DIV_W-1:0] div_cnt_reg;
   logic             phase_reg;

   // Divider restarts from the low phase whenever it is disabled
   always_ff @(posedge clk) begin
      if (srst || !en) begin
         div_cnt_reg <= '0;
         phase_reg   <= 1'b0;
      end else if (div_cnt_reg == DIV_LAST) begin
         div_cnt_reg <= '0;
         phase_reg   <= ~phase_reg;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

   assign sclk     = phase_reg;
   assign fall_stb = en && !phase_reg && (div_cnt_reg == '0);
   assign rise_stb = en &&  phase_reg && (div_cnt_reg == '0);
   assign end_stb  = en &&  phase_reg && (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/cfg_serial_loader.sv
// Collects a configuration frame byte-by-byte from a host, shifts it MSB
// first into an external config shift register and compares the bits that
// come back out of the chain against the previously loaded frame.
module cfg_serial_loader
   import cfg_serial_loader_pkg::*;
#(
   parameter int SIZESRSTAT = SIZESRSTAT_DEF,
   parameter int SIZESRDYN  = SIZESRDYN_DEF,
   parameter int CLKDIV     = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] BYTE_IN,
   input  logic       BYTE_VALID,
   output logic       BYTE_READY,
   output logic       SCLK_OUT,
   output logic       SEL_OUT,
   output logic       SDI_OUT,
   input  logic       SDO_IN,
   output logic       BUSY,
   output logic       DONE,
   output logic       RB_ERR
);

   // Frame geometry; frames are assumed longer than one byte
   localparam int N      = SIZESRSTAT + SIZESRDYN;
   localparam int B      = frame_bytes(N);
   localparam int BW     = B * 8;
   localparam int BIT_W  = $clog2(N + 1);
   localparam int BYTE_W = $clog2(B + 1);

   state_t state_reg, state_next;

   logic [BYTE_W-1:0] byte_cnt_reg;
   logic [BIT_W-1:0]  bit_cnt_reg;
   logic [BW-1:0]     load_reg;
   logic [N-1:0]      rb_reg;
   logic [N-1:0]      prev_reg;
   logic              prev_valid_reg;
   logic              rb_err_reg;

   logic sclk_int, fall_stb, rise_stb, end_stb;
   logic gen_en;
   logic byte_acc;
   logic shifting;
   logic latch_end;

   // The divider also times the LATCH hold, whose length equals one bit period
   assign gen_en    = (state_reg == ST_SHIFT) || (state_reg == ST_LATCH);
   assign byte_acc  = BYTE_VALID && BYTE_READY;
   assign shifting  = (state_reg == ST_SHIFT);
   assign latch_end = (state_reg == ST_LATCH) && end_stb;

   cfg_sclk_gen #(
      .CLKDIV (CLKDIV)
   ) u_sclk_gen (
      .clk      (CLK),
      .srst     (RST),
      .en       (gen_en),
      .sclk     (sclk_int),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb),
      .end_stb  (end_stb)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state and output decode
   always_comb begin
      state_next = state_reg;
      BYTE_READY = 1'b0;
      SEL_OUT    = 1'b0;
      SCLK_OUT   = 1'b0;
      SDI_OUT    = 1'b0;
      BUSY       = 1'b1;
      DONE       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            BUSY       = 1'b0;
            BYTE_READY = !RST;
            if (byte_acc) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            BYTE_READY = !RST;
            if (byte_acc && (byte_cnt_reg == BYTE_W'(B - 1))) state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            SEL_OUT  = 1'b1;
            SCLK_OUT = sclk_int;
            SDI_OUT  = load_reg[N-1];
            // bit_cnt counts periods started, so N here means the last bit ends now
            if (end_stb && (bit_cnt_reg == BIT_W'(N))) state_next = ST_LATCH;
         end
         ST_LATCH: begin
            if (end_stb) state_next = ST_FIN;
         end
         ST_FIN: begin
            DONE       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Byte collection; the top pad bits of byte 0 fall off above bit N-1
   always_ff @(posedge CLK) begin
      if (RST) begin
         byte_cnt_reg <= '0;
         load_reg     <= '0;
      end else if (byte_acc) begin
         load_reg     <= {load_reg[BW-9:0], BYTE_IN};
         byte_cnt_reg <= (state_reg == ST_IDLE) ? BYTE_W'(1) : byte_cnt_reg + 1'b1;
      end else if (shifting && end_stb) begin
         // Rotate so the frame is intact again after N bits and can become the reference
         load_reg[N-1:0] <= {load_reg[N-2:0], load_reg[N-1]};
      end
   end

   // Bit period counter, cleared outside SHIFT
   always_ff @(posedge CLK) begin
      if (RST || !shifting) bit_cnt_reg <= '0;
      else if (fall_stb)    bit_cnt_reg <= bit_cnt_reg + 1'b1;
   end

   // Readback capture on each serial clock rise, first sample lands in the MSB
   always_ff @(posedge CLK) begin
      if (RST)                       rb_reg <= '0;
      else if (shifting && rise_stb) rb_reg <= {rb_reg[N-2:0], SDO_IN};
   end

   // Compare and record the reference on entry to FIN so RB_ERR is valid with DONE
   always_ff @(posedge CLK) begin
      if (RST) begin
         prev_reg       <= '0;
         prev_valid_reg <= 1'b0;
         rb_err_reg     <= 1'b0;
      end else if (latch_end) begin
         rb_err_reg     <= prev_valid_reg && (rb_reg != prev_reg);
         prev_reg       <= load_reg[N-1:0];
         prev_valid_reg <= 1'b1;
      end
   end

   assign RB_ERR = rb_err_reg;

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Directed bench for cfg_serial_loader: a default instance driving a loopback
// chain model and a short-frame CLKDIV=2 instance.
module tb_cfg_serial_loader;

   localparam int N  = 104;
   localparam int N2 = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, rst2;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       dsel;

   logic ready1, sclk1, sel1, sdi1, sdo1, busy1, done1, rberr1;
   logic ready2, sclk2, sel2, sdi2, busy2, done2, rberr2;
   logic sdo2;
   assign sdo2 = 1'b0;

   cfg_serial_loader u_dut (
      .CLK        (clk),
      .RST        (rst1),
      .BYTE_IN    (byte_in),
      .BYTE_VALID (byte_valid & ~dsel),
      .BYTE_READY (ready1),
      .SCLK_OUT   (sclk1),
      .SEL_OUT    (sel1),
      .SDI_OUT    (sdi1),
      .SDO_IN     (sdo1),
      .BUSY       (busy1),
      .DONE       (done1),
      .RB_ERR     (rberr1)
   );

   cfg_serial_loader #(
      .SIZESRSTAT (10),
      .SIZESRDYN  (3),
      .CLKDIV     (2)
   ) u_dut2 (
      .CLK        (clk),
      .RST        (rst2),
      .BYTE_IN    (byte_in),
      .BYTE_VALID (byte_valid & dsel),
      .BYTE_READY (ready2),
      .SCLK_OUT   (sclk2),
      .SEL_OUT    (sel2),
      .SDI_OUT    (sdi2),
      .SDO_IN     (sdo2),
      .BUSY       (busy2),
      .DONE       (done2),
      .RB_ERR     (rberr2)
   );

   // Observed signals of whichever instance is under test
   logic o_ready, o_sclk, o_sel, o_sdi, o_busy, o_done, o_rberr;
   assign o_ready = dsel ? ready2 : ready1;
   assign o_sclk  = dsel ? sclk2  : sclk1;
   assign o_sel   = dsel ? sel2   : sel1;
   assign o_sdi   = dsel ? sdi2   : sdi1;
   assign o_busy  = dsel ? busy2  : busy1;
   assign o_done  = dsel ? done2  : done1;
   assign o_rberr = dsel ? rberr2 : rberr1;

   // Loopback chain: the loader samples the old MSB, then the chain shifts
   logic [N-1:0] chain = '0;
   logic         chain_sclk_q = 1'b0;
   logic         flip_req = 1'b0;
   assign sdo1 = chain[N-1];
   always @(posedge clk) begin
      if (flip_req)                   chain[7] <= ~chain[7];
      else if (sclk1 && !chain_sclk_q) chain <= {chain[N-2:0], sdi1};
      chain_sclk_q <= sclk1;
   end

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] fb [0:12];
   logic       obs_bits   [0:127];
   logic       basic_bits [0:127];
   int sel_cyc, rises, dones, ready_hi, sdi_glitch, r0, r1;
   logic rb_seen;

   // Present nb bytes from fb, waiting on BYTE_READY, with gap idle cycles between
   task automatic send_bytes(input int nb, input int gap);
      for (int k = 0; k < nb; k++) begin
         byte_in    = fb[k];
         byte_valid = 1'b1;
         for (int w = 0; w < 200 && !o_ready; w++) @(negedge clk);
         @(negedge clk);
         if (gap > 0 && k < nb - 1) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      byte_valid = 1'b0;
      byte_in    = 8'h00;
   endtask

   // Observe from the first SHIFT cycle until DONE or until stop_rise rises were seen
   task automatic watch_frame(input int stop_rise);
      logic sclk_q, sel_q, sdi_q;
      sclk_q = 1'b0; sel_q = 1'b0; sdi_q = 1'b0;
      sel_cyc = 0; rises = 0; dones = 0; ready_hi = 0; sdi_glitch = 0;
      r0 = -1; r1 = -1; rb_seen = 1'bx;
      for (int c = 0; c < 4000 && dones == 0 && rises < stop_rise; c++) begin
         if (o_sel) sel_cyc++;
         if (o_sclk && !sclk_q) begin
            if (rises < 128) obs_bits[rises] = o_sdi;
            if (rises == 0) r0 = c;
            if (rises == 1) r1 = c;
            rises++;
         end
         if (o_sel && sel_q && (o_sdi !== sdi_q) && !(sclk_q && !o_sclk)) sdi_glitch++;
         if (o_ready) ready_hi++;
         if (o_done) begin
            dones++;
            rb_seen = o_rberr;
         end
         sclk_q = o_sclk; sel_q = o_sel; sdi_q = o_sdi;
         @(negedge clk);
      end
      if (stop_rise > N) begin
         for (int c = 0; c < 20; c++) begin
            if (o_done) dones++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst1 = 1'b1; rst2 = 1'b1; dsel = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (3) @(negedge clk);
      vectors++;
      if ({ready1, sclk1, sel1, sdi1, busy1, done1, rberr1} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_outs: got %b expected 0000000", {ready1, sclk1, sel1, sdi1, busy1, done1, rberr1});
      end
      vectors++;
      if ({ready2, sclk2, sel2, sdi2, busy2, done2, rberr2} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_outs2: got %b expected 0000000", {ready2, sclk2, sel2, sdi2, busy2, done2, rberr2});
      end
      rst1 = 1'b0; rst2 = 1'b0;
      @(negedge clk);
      vectors++;
      if ({ready1, busy1, ready2, busy2} !== 4'b1010) begin
         miscompares++;
         $display("FAIL idle_ready: got %b expected 1010", {ready1, busy1, ready2, busy2});
      end
      $display("reset: done");
   endtask

   task automatic check_frame(input string tag, input int exp_rises, input int exp_sel, input logic exp_rb);
      vectors++;
      if (rises !== exp_rises) begin
         miscompares++;
         $display("FAIL %s_rises: got %0d expected %0d", tag, rises, exp_rises);
      end
      vectors++;
      if (sel_cyc !== exp_sel) begin
         miscompares++;
         $display("FAIL %s_sel_cycles: got %0d expected %0d", tag, sel_cyc, exp_sel);
      end
      vectors++;
      if (dones !== 1) begin
         miscompares++;
         $display("FAIL %s_done_count: got %0d expected 1", tag, dones);
      end
      vectors++;
      if (rb_seen !== exp_rb) begin
         miscompares++;
         $display("FAIL %s_rb_err: got %b expected %b", tag, rb_seen, exp_rb);
      end
      vectors++;
      if (ready_hi !== 0 || sdi_glitch !== 0) begin
         miscompares++;
         $display("FAIL %s_ready_sdi: ready_hi %0d glitches %0d expected 0 0", tag, ready_hi, sdi_glitch);
      end
      $display("frame %s: rises %0d sel %0d done %0d rb_err %b", tag, rises, sel_cyc, dones, rb_seen);
   endtask

   task automatic check_seq104(input string tag);
      logic [N-1:0] v;
      int bad;
      v = '0;
      for (int k = 0; k < 13; k++) v = {v[N-9:0], fb[k]};
      bad = 0;
      for (int i = 0; i < N; i++) if (obs_bits[i] !== v[N-1-i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL %s_sdi_seq: got %0d wrong bits expected 0", tag, bad);
      end
   endtask

   task automatic test_basic();
      fb[0] = 8'hFF;
      for (int k = 1; k < 12; k++) fb[k] = 8'h00;
      fb[12] = 8'hA5;
      send_bytes(13, 0);
      watch_frame(1000);
      check_frame("basic", 104, 832, 1'b0);
      check_seq104("basic");
      vectors++;
      if ({obs_bits[0], obs_bits[7], obs_bits[8], obs_bits[96], obs_bits[97], obs_bits[103]} !== 6'b110101) begin
         miscompares++;
         $display("FAIL basic_spot_bits: got %b expected 110101",
                  {obs_bits[0], obs_bits[7], obs_bits[8], obs_bits[96], obs_bits[97], obs_bits[103]});
      end
      for (int i = 0; i < 128; i++) basic_bits[i] = obs_bits[i];
   endtask

   task automatic test_gaps();
      int bad;
      send_bytes(13, 3);
      watch_frame(1000);
      check_frame("gaps", 104, 832, 1'b0);
      bad = 0;
      for (int i = 0; i < N; i++) if (obs_bits[i] !== basic_bits[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL gaps_vs_backtoback: got %0d differing bits expected 0", bad);
      end
   endtask

   task automatic load_pattern(input logic [7:0] seed);
      for (int k = 0; k < 13; k++) fb[k] = seed ^ 8'(k * 29);
   endtask

   task automatic test_loopback();
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
      @(negedge clk);
      load_pattern(8'h3C);
      send_bytes(13, 0); watch_frame(1000); check_frame("loopA1", 104, 832, 1'b0);
      check_seq104("loopA1");
      send_bytes(13, 0); watch_frame(1000); check_frame("loopA2", 104, 832, 1'b0);
      load_pattern(8'hC9);
      send_bytes(13, 0); watch_frame(1000); check_frame("loopB", 104, 832, 1'b0);
      flip_req = 1'b1;
      @(negedge clk);
      flip_req = 1'b0;
      load_pattern(8'h71);
      send_bytes(13, 0); watch_frame(1000); check_frame("loopC", 104, 832, 1'b1);
      vectors++;
      if (rberr1 !== 1'b1) begin
         miscompares++;
         $display("FAIL rb_err_hold: got %b expected 1", rberr1);
      end
      load_pattern(8'h0F);
      send_bytes(13, 0); watch_frame(1000); check_frame("loopD", 104, 832, 1'b0);
   endtask

   task automatic test_abort();
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
      @(negedge clk);
      load_pattern(8'h5E);
      send_bytes(13, 0);
      watch_frame(51);
      vectors++;
      if (rises !== 51 || sel1 !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_reach_bit50: got rises %0d sel %b expected 51 1", rises, sel1);
      end
      rst1 = 1'b1;
      @(negedge clk);
      vectors++;
      if ({sel1, sclk1, busy1, done1, ready1} !== 5'b0) begin
         miscompares++;
         $display("FAIL abort_outs: got %b expected 00000", {sel1, sclk1, busy1, done1, ready1});
      end
      rst1 = 1'b0;
      @(negedge clk);
      vectors++;
      if ({ready1, busy1, rberr1} !== 3'b100) begin
         miscompares++;
         $display("FAIL abort_idle: got %b expected 100", {ready1, busy1, rberr1});
      end
      send_bytes(13, 0); watch_frame(1000); check_frame("after_abort", 104, 832, 1'b0);
      $display("abort: done");
   endtask

   task automatic test_clkdiv2();
      logic [N2-1:0] got;
      dsel = 1'b1;
      fb[0] = 8'h80; fb[1] = 8'h5A;
      send_bytes(2, 0); watch_frame(1000); check_frame("div2_a", 13, 52, 1'b0);
      got = '0;
      for (int i = 0; i < N2; i++) got = {got[N2-2:0], obs_bits[i]};
      vectors++;
      if (got !== 13'b0000001011010) begin
         miscompares++;
         $display("FAIL div2_seq_a: got %b expected 0000001011010", got);
      end
      vectors++;
      if (r1 - r0 !== 4) begin
         miscompares++;
         $display("FAIL div2_sclk_period: got %0d expected 4", r1 - r0);
      end
      fb[0] = 8'hF0; fb[1] = 8'h01;
      send_bytes(2, 0); watch_frame(1000); check_frame("div2_b", 13, 52, 1'b1);
      got = '0;
      for (int i = 0; i < N2; i++) got = {got[N2-2:0], obs_bits[i]};
      vectors++;
      if (got !== 13'b1000000000001) begin
         miscompares++;
         $display("FAIL div2_seq_b: got %b expected 1000000000001", got);
      end
      dsel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_loopback();
      test_abort();
      test_clkdiv2();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
